// File: rtl/mips_instr_loader_pkg.sv
// Shared opcode, record-kind and FSM-state definitions for the instruction loader.
// The opcode constants are the same ones the CPU's main decoder uses.
package mips_instr_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_ADDI = 3'd4,
    KIND_J    = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DONE = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/mips_instr_loader_encoder.sv
// Combinational formatter: turns one instruction record into a 32-bit MIPS word.
// Kinds 6 and 7 produce a zero word and raise o_illegal.
module instr_field_encoder
  import mips_instr_loader_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (i_kind)
      KIND_R:    o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'b00000, i_funct};
      KIND_LW:   o_word = {OP_LW,    i_rs, i_rt, i_imm};
      KIND_SW:   o_word = {OP_SW,    i_rs, i_rt, i_imm};
      KIND_BEQ:  o_word = {OP_BEQ,   i_rs, i_rt, i_imm};
      KIND_ADDI: o_word = {OP_ADDI,  i_rs, i_rt, i_imm};
      KIND_J:    o_word = {OP_J,     i_target};
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// Streams instruction records into instruction memory and holds the CPU in reset
// until the program is loaded.
//   state   | meaning
//   ST_LOAD | accepting records, CPU held
//   ST_DONE | program loaded, CPU released
//   ST_ERR  | illegal record seen, CPU held
module mips_instr_loader
  import mips_instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [10:0] word_count
);

  localparam logic [10:0] LAST_IDX = 11'(DEPTH - 1);

  state_e      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_hold;
  logic        r_done;
  logic        r_err;
  logic [10:0] r_count;

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_accept;

  instr_field_encoder u_enc (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_funct   (in_funct),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign in_ready = (r_state == ST_LOAD);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= 32'h0000_0000;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 11'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= BASE_ADDR + {19'd0, r_count, 2'b00};
              r_wdata <= w_word;
              r_count <= r_count + 11'd1;
              // The slot at DEPTH-1 closes the session even without in_last.
              if (in_last || (r_count == LAST_IDX)) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (restart) begin
            r_state <= ST_LOAD;
            r_count <= 11'd0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_count;

endmodule

// File: doc/mips_instr_loader.md
MIPS_INSTR_LOADER -- requirements
Module: mips_instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000; byte address of the first instruction word written.
REQ-002 Parameter DEPTH, default 64; maximum number of words per load session, range 2..1024.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  source presents an instruction record.
REQ-006 in_ready  out  1  loader accepts the record this cycle.
REQ-007 in_kind  in  3  record type: 0 R-type, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; 6 and 7 are illegal.
REQ-008 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-009 in_funct  in  6  R-type function field.
REQ-010 in_imm  in  16  immediate or branch offset.
REQ-011 in_target  in  26  jump target field.
REQ-012 in_last  in  1  marks the final record of the program.
REQ-013 restart  in  1  starts a new load session from DONE or ERR.
REQ-014 imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-015 imem_addr  out  32  byte address of the write.
REQ-016 imem_wdata  out  32  encoded instruction word.
REQ-017 cpu_hold  out  1  holds the CPU in reset while high.
REQ-018 load_done  out  1  program loaded successfully.
REQ-019 load_err  out  1  illegal in_kind was received (sticky).
REQ-020 word_count  out  11  number of words written in the current session.

Function
REQ-021 The FSM SHALL have three states: LOAD, DONE and ERR.
REQ-022 In LOAD, in_ready SHALL be 1; in DONE and ERR it SHALL be 0.
REQ-023 A record SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_valid may be held high across cycles.
REQ-024 Encoding of each kind:
  - R: {6'b000000, rs, rt, rd, 5'b00000, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - ADDI: {6'b001000, rs, rt, imm}
  - J: {6'b000010, target}
REQ-025 Write latency SHALL be exactly 1 cycle from acceptance: the following cycle has imem_we=1, imem_addr=BASE_ADDR+4*word_count (pre-increment value) and imem_wdata=the encoded word.
REQ-026 word_count SHALL increment in that same cycle; imem_addr SHALL be computed modulo 2^32.
REQ-027 Back-to-back acceptances SHALL produce back-to-back writes with no bubbles.
REQ-028 LOAD to DONE SHALL occur on accepting a record with in_last=1, or on accepting the record at index DEPTH-1 regardless of in_last.
REQ-029 LOAD to ERR SHALL occur on accepting an illegal in_kind; that record SHALL NOT be written and word_count SHALL be unchanged.
REQ-030 In DONE: load_done=1 and cpu_hold=0. In ERR: load_err=1, cpu_hold=1, load_done=0.
REQ-031 restart=1 in DONE or ERR SHALL return the FSM to LOAD with word_count=0, cpu_hold=1, load_done=0, load_err=0 on the next cycle.
REQ-032 restart SHALL be ignored in LOAD.
REQ-033 A final write issued in the transition cycle SHALL still complete even if restart is asserted in that cycle.
REQ-034 in_valid and restart asserted together while in DONE: restart wins and no record is accepted (in_ready=0).

Reset
REQ-035 On reset=1 at a clock edge, the next state SHALL be: LOAD, word_count=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0.
REQ-036 Reset SHALL override restart and any pending acceptance, including mid-session; any write scheduled for the next cycle is cancelled.

Structure
REQ-037 A shared package SHALL hold the six opcode constants, the in_kind codes and the FSM state encoding; main_decoder SHALL use the same opcode constants.
REQ-038 Word formatting SHALL live in a combinational sub-module instr_field_encoder (kind/fields in, 32-bit word and illegal flag out).
REQ-039 All state, counters and output registers SHALL live in mips_instr_loader.

Verification
REQ-040 Reset, then 3 records (ADDI rs=0 rt=8 imm=5; LW rs=8 rt=9 imm=4; J target=0, last) -> writes at 0x0, 0x4, 0x8 with words 0x20080005, 0x8D090004, 0x08000000; DONE; cpu_hold=0.
REQ-041 R-type rs=8 rt=9 rd=10 funct=0x20 -> word 0x01095020; in_valid held high for 4 records -> 4 consecutive imem_we cycles.
REQ-042 With DEPTH=4, 5 records and no in_last -> exactly 4 writes; DONE after the 4th; 5th record never accepted.
REQ-043 in_kind=6 as the 2nd record -> only 1 write; load_err=1; cpu_hold=1; restart -> LOAD with word_count=0 and next write at BASE_ADDR.
REQ-044 reset asserted the cycle after an acceptance -> no imem_we that cycle; all outputs at reset values.
REQ-045 restart and in_valid both high in DONE -> no write; LOAD next cycle; the record is accepted the following cycle at address 0x0.
